video_rgb_adapter: RTL

//  Parametrised video output stage between a core's raw pixel/sync outputs and the 8-bit-per-channel VGA_* outputs of the sim top and MiSTer wrapper.

---
 rtl/video_rgb_adapter_pkg.sv | 12 +
 rtl/video_rgb_adapter_if.sv | 26 ++
 rtl/video_rgb_adapter_palette.sv | 23 ++
 rtl/video_rgb_adapter.sv | 99 +++++++++
 4 files changed

// File: rtl/video_rgb_adapter_pkg.sv
// video_pkg: shared mode constants and pixel-expansion helper for the video output stage
package video_pkg;
  localparam int MODE_MONO = 0;
  localparam int MODE_RGB  = 1;
  localparam int MODE_PAL  = 2;
  // MSB-first replication of the low `bits` bits of value, truncated to 8 bits
  function automatic logic [7:0] expand_to8(input logic [8:0] value, input int bits);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[3'(7 - i)] = value[4'(bits - 1 - (i % bits))];
    return r;
  endfunction
endpackage

// File: rtl/video_rgb_adapter_if.sv
// video_rgb_adapter_if: core-side pixel/sync/palette inputs and VGA/geometry outputs
//   master: drives video_in, syncs, blanks, palette write; reads ce_pix, VGA_*, counters
//   slave : the adapter
interface video_rgb_adapter_if #(
  parameter int IN_BITS = 1,
  parameter int CNT_W   = 11
);
  logic [IN_BITS-1:0] video_in;
  logic               hsync_in, vsync_in, hblank_in, vblank_in;
  logic               pal_we;
  logic [IN_BITS-1:0] pal_addr;
  logic [23:0]        pal_data;
  logic               ce_pix;
  logic [7:0]         VGA_R, VGA_G, VGA_B;
  logic               VGA_HS, VGA_VS, VGA_HB, VGA_VB;
  logic [CNT_W-1:0]   h_count, v_count;
  logic [15:0]        frame_cnt;
  modport master (
    output video_in, hsync_in, vsync_in, hblank_in, vblank_in, pal_we, pal_addr, pal_data,
    input  ce_pix, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_HB, VGA_VB, h_count, v_count, frame_cnt
  );
  modport slave (
    input  video_in, hsync_in, vsync_in, hblank_in, vblank_in, pal_we, pal_addr, pal_data,
    output ce_pix, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_HB, VGA_VB, h_count, v_count, frame_cnt
  );
endinterface

// File: rtl/video_rgb_adapter_palette.sv
// video_palette_ram: 2^AW x 24 palette, one write port, one synchronous read port
//   clk, we/waddr/wdata (write next edge), raddr -> rdata (registered, old data on collision)
module video_palette_ram #(
  parameter int AW = 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [23:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [23:0]   rdata
);
  localparam int DEPTH = 2 ** AW;
  logic [23:0] mem [DEPTH];
  logic [23:0] rd_q;
  // power-up contents: grey ramp from black to white
  initial for (int i = 0; i < DEPTH; i++) mem[i] = {3{8'(i * 255 / (DEPTH - 1))}};
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_q <= mem[raddr];
  end
  assign rdata = rd_q;
endmodule

// File: rtl/video_rgb_adapter.sv
// video_rgb_adapter: pixel clock-enable, 2-stage ce_pix pipeline, colour expansion, geometry counters
//   clk, reset (sync, active-high), vif (slave): core pixel/syncs/blanks/palette in,
//   ce_pix, VGA_R/G/B/HS/VS/HB/VB, h_count, v_count, frame_cnt out
module video_rgb_adapter
  import video_pkg::*;
#(
  parameter int IN_BITS = 1,
  parameter int MODE    = MODE_MONO,
  parameter int PIX_DIV = 1,
  parameter int CNT_W   = 11
) (
  input logic                clk,
  input logic                reset,
  video_rgb_adapter_if.slave vif
);
  localparam int C = (MODE == MODE_RGB) ? IN_BITS / 3 : 1;
  initial begin
    if (IN_BITS < 1 || IN_BITS > 9) $error("IN_BITS must be 1..9");
    if (MODE < MODE_MONO || MODE > MODE_PAL) $error("MODE must be 0..2");
    if (MODE == MODE_RGB && IN_BITS % 3 != 0) $error("packed RGB needs IN_BITS divisible by 3");
    if (PIX_DIV < 1 || PIX_DIV > 16) $error("PIX_DIV must be 1..16");
  end
  typedef struct packed {
    logic [IN_BITS-1:0] pix;
    logic               hs, vs, hb, vb;
  } s1_t;
  logic [3:0]       div_q, div_d;
  logic             ce_q, ce_d;
  s1_t              s1_q, s1_d;
  logic [23:0]      rgb_q, rgb_d, rgb_conv, pal_rd;
  logic [3:0]       sync_q, sync_d;
  logic [CNT_W-1:0] pix_q, pix_d, line_q, line_d, hcnt_q, hcnt_d, vcnt_q, vcnt_d, line_inc;
  logic [15:0]      frm_q, frm_d;
  logic [8:0]       pix9;
  logic             hs_rise, vs_rise;
  // the palette is addressed with the value S1 is about to hold so its read latency
  // completes before S2 samples it
  if (MODE == MODE_PAL) begin : g_pal
    video_palette_ram #(.AW(IN_BITS)) u_pal (
      .clk(clk), .we(vif.pal_we), .waddr(vif.pal_addr), .wdata(vif.pal_data),
      .raddr(s1_d.pix), .rdata(pal_rd)
    );
  end else begin : g_nopal
    logic unused_pal;
    assign unused_pal = ^{vif.pal_we, vif.pal_addr, vif.pal_data};
    assign pal_rd = '0;
  end
  always_comb begin
    div_d = (div_q == 4'(PIX_DIV - 1)) ? '0 : div_q + 4'd1;
    ce_d = div_q == 4'(PIX_DIV - 1);
    s1_d = ce_q ? s1_t'({vif.video_in, vif.hsync_in, vif.vsync_in, vif.hblank_in, vif.vblank_in}) : s1_q;
    pix9 = 9'(s1_q.pix);
    rgb_conv = (MODE == MODE_PAL) ? pal_rd
             : (MODE == MODE_RGB) ? {expand_to8(pix9 >> (2 * C), C), expand_to8(pix9 >> C, C), expand_to8(pix9, C)}
             : {3{expand_to8(pix9, IN_BITS)}};
    rgb_d = ce_q ? ((s1_q.hb | s1_q.vb) ? '0 : rgb_conv) : rgb_q;
    sync_d = ce_q ? {s1_q.hs, s1_q.vs, s1_q.hb, s1_q.vb} : sync_q;
    // S2 sync registers hold the previous S1 value, so they double as edge history
    hs_rise = ce_q & s1_q.hs & ~sync_q[3];
    vs_rise = ce_q & s1_q.vs & ~sync_q[2];
    pix_d = hs_rise ? CNT_W'(1) : (ce_q && pix_q != '1) ? pix_q + 1'b1 : pix_q;
    hcnt_d = hs_rise ? pix_q : hcnt_q;
    line_inc = hs_rise ? line_q + 1'b1 : line_q;
    line_d = vs_rise ? '0 : line_inc;
    vcnt_d = vs_rise ? line_inc : vcnt_q;
    frm_d = frm_q + 16'(vs_rise);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      ce_q   <= 1'b0;
      s1_q   <= '0;
      rgb_q  <= '0;
      sync_q <= '0;
      pix_q  <= '0;
      line_q <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
      frm_q  <= '0;
    end else begin
      div_q  <= div_d;
      ce_q   <= ce_d;
      s1_q   <= s1_d;
      rgb_q  <= rgb_d;
      sync_q <= sync_d;
      pix_q  <= pix_d;
      line_q <= line_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      frm_q  <= frm_d;
    end
  end
  assign vif.ce_pix = ce_q;
  assign {vif.VGA_R, vif.VGA_G, vif.VGA_B} = rgb_q;
  assign {vif.VGA_HS, vif.VGA_VS, vif.VGA_HB, vif.VGA_VB} = sync_q;
  assign vif.h_count = hcnt_q;
  assign vif.v_count = vcnt_q;
  assign vif.frame_cnt = frm_q;
endmodule
